// File: rtl/equiv_check_pkg.sv
// Shared types and helpers for the spec-vs-impl equivalence check engine.
package equiv_check_pkg;

    localparam int          CNT_W     = 16;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        CHECK,
        DONE
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/equiv_lfsr.sv
// 32-bit right-shifting Galois LFSR with seed load and step enable.
module equiv_lfsr
    import equiv_check_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    // Next state: load has priority over step.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED;
        end else if (step) begin
            state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_TAPS : 32'h0);
        end
    end

    // State register; reset returns to the seed so a fresh run replays.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/equiv_check_engine.sv
// Equivalence check engine: drives LFSR stimulus, waits SETTLE cycles, compares
// NCH channels of spec vs impl, counts failing vectors and captures the first.
// Optional build macro EQUIV_XCHECK_EN: any X/Z on an impl channel is also a
// mismatch, and each such vector is reported with a $display line.
module equiv_check_engine
    import equiv_check_pkg::*;
#(
    parameter int          NCH    = 11,
    parameter int          W      = 41,
    parameter int          SW     = 12,
    parameter int          NVEC   = 1000,
    parameter int          SETTLE = 10,
    parameter logic [31:0] SEED   = 32'hACE1_2014
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [SW-1:0]        stim,
    input  logic [NCH*W-1:0]     spec_flat,
    input  logic [NCH*W-1:0]     impl_flat,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     fail_count,
    output logic [CNT_W-1:0]     vec_index,
    output logic [CNT_W-1:0]     first_fail_vec,
    output logic [SW-1:0]        first_fail_stim,
    output logic [NCH-1:0]       first_fail_mask
);

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam int          SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // Vector counter is 32 bits so runs longer than 64K vectors still end on time.
    localparam logic [31:0] LAST_VEC = 32'(NVEC - 1);

    state_e             state_q,    state_d;
    logic [SW-1:0]      stim_q,     stim_d;
    logic [SET_W-1:0]   settle_q,   settle_d;
    logic [31:0]        vec_q,      vec_d;
    logic [CNT_W-1:0]   fail_q,     fail_d;
    logic [CNT_W-1:0]   ff_vec_q,   ff_vec_d;
    logic [SW-1:0]      ff_stim_q,  ff_stim_d;
    logic [NCH-1:0]     ff_mask_q,  ff_mask_d;

    logic               lfsr_load;
    logic               lfsr_step;
    logic [31:0]        lfsr_state;
    logic [NCH-1:0]     mask;
`ifdef EQUIV_XCHECK_EN
    logic [NCH-1:0]     x_mask;
`endif

    equiv_lfsr #(.SEED(SEED_EFF)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // Per-channel mismatch; case inequality makes X match X and Z match Z.
    always_comb begin
        mask = '0;
`ifdef EQUIV_XCHECK_EN
        x_mask = '0;
`endif
        for (int k = 0; k < NCH; k++) begin
            mask[k] = (impl_flat[k*W +: W] !== spec_flat[k*W +: W]);
`ifdef EQUIV_XCHECK_EN
            x_mask[k] = $isunknown(impl_flat[k*W +: W]);
            mask[k]   = mask[k] | x_mask[k];
`endif
        end
    end

    // FSM next state and datapath updates.
    always_comb begin
        // NOTE: every variable gets its default first so no path infers a latch.
        state_d   = state_q;
        stim_d    = stim_q;
        settle_d  = settle_q;
        vec_d     = vec_q;
        fail_d    = fail_q;
        ff_vec_d  = ff_vec_q;
        ff_stim_d = ff_stim_q;
        ff_mask_d = ff_mask_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = LOAD;
                    vec_d     = '0;
                    fail_d    = '0;
                    ff_vec_d  = '0;
                    ff_stim_d = '0;
                    ff_mask_d = '0;
                    lfsr_load = 1'b1;
                end
            end
            LOAD: begin
                stim_d    = lfsr_state[SW-1:0];
                lfsr_step = 1'b1;
                settle_d  = SET_W'(SETTLE - 1);
                state_d   = WAIT;
            end
            WAIT: begin
                if (settle_q == '0) begin
                    state_d = CHECK;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            CHECK: begin
                if (|mask) begin
                    fail_d = sat_inc(fail_q);
                    // fail_count saturates and never wraps, so zero means "no capture yet".
                    if (fail_q == '0) begin
                        ff_vec_d  = vec_q[CNT_W-1:0];
                        ff_stim_d = stim_q;
                        ff_mask_d = mask;
                    end
                end
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 32'd1;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q   <= IDLE;
            stim_q    <= '0;
            settle_q  <= '0;
            vec_q     <= '0;
            fail_q    <= '0;
            ff_vec_q  <= '0;
            ff_stim_q <= '0;
            ff_mask_q <= '0;
        end else begin
            state_q   <= state_d;
            stim_q    <= stim_d;
            settle_q  <= settle_d;
            vec_q     <= vec_d;
            fail_q    <= fail_d;
            ff_vec_q  <= ff_vec_d;
            ff_stim_q <= ff_stim_d;
            ff_mask_q <= ff_mask_d;
        end
    end

`ifdef EQUIV_XCHECK_EN
    // Report each checked vector whose impl outputs carry X/Z.
    always_ff @(posedge clk) begin
        if (!reset && state_q == CHECK && |x_mask) begin
            $display("equiv_check_engine: X/Z on impl at vector %0d stim %h mask %b",
                     vec_q, stim_q, mask);
        end
    end
`endif

    assign stim            = stim_q;
    assign busy            = (state_q == LOAD) || (state_q == WAIT) || (state_q == CHECK);
    assign done            = (state_q == DONE);
    assign pass            = done && (fail_q == '0);
    assign fail_count      = fail_q;
    assign vec_index       = vec_q[CNT_W-1:0];
    assign first_fail_vec  = ff_vec_q;
    assign first_fail_stim = ff_stim_q;
    assign first_fail_mask = ff_mask_q;

endmodule
